// File: rtl/echo_portal_pkg.sv
// Shared definitions for the echo indication portal: word width, message
// length, method tag and the beat sequence used to serialize a call.
package echo_portal_pkg;

    localparam int WORD_W     = 32;
    localparam int MSG_LEN    = 3;
    localparam int RULE_COUNT = 0;

    localparam logic [15:0] TAG_HEARD = 16'd1;

    typedef enum logic [1:0] {
        BEAT_HDR  = 2'd0,
        BEAT_METH = 2'd1,
        BEAT_VAL  = 2'd2
    } beat_e;

    // Header word: message length in words (upper half), method tag (lower half).
    function automatic logic [WORD_W-1:0] make_header(input logic [15:0] tag);
        return {16'(MSG_LEN), tag};
    endfunction

endpackage

// File: rtl/echo_msg_fifo.sv
// DEPTH-entry synchronous FIFO holding buffered heard calls as {meth, v}.
// Head data is presented combinationally; storage is not reset.
module echo_msg_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              deq,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_enq;
    logic              do_deq;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_enq    = enq && !full;
    assign do_deq    = deq && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/echo_indication_output.sv
// Transmit end of the echo indication portal: buffers heard(meth, v) calls and
// sends each as header/meth/v words. Optional counters: ECHO_INDICATION_OUTPUT_STATS_EN.
module echo_indication_output #(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] TAG_HEARD = echo_portal_pkg::TAG_HEARD
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        heard__ENA,
    input  logic [31:0] heard_meth,
    input  logic [31:0] heard_v,
    output logic        heard__RDY,
    output logic        pipe_enq__ENA,
    output logic [31:0] pipe_enq_v,
    input  logic        pipe_enq__RDY,
    input  logic        rule_enable,
    output logic        rule_ready
`ifdef ECHO_INDICATION_OUTPUT_STATS_EN
    ,
    output logic [15:0] msg_count,
    output logic [15:0] drop_count
`endif
);

    import echo_portal_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_HDR  = BEAT_HDR;
    localparam logic [1:0] S_METH = BEAT_METH;
    localparam logic [1:0] S_VAL  = BEAT_VAL;

    logic [1:0]          beat;
    logic [1:0]          beat_next;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [2*WORD_W-1:0] head;
    logic                enq;
    logic                deq;
    logic                unused_fifo_count;

    // Readiness is forced low while reset is held so nothing is accepted or sent.
    assign heard__RDY    = !nRST && !fifo_full;
    assign rule_ready    = !nRST && !fifo_empty && pipe_enq__RDY;
    assign pipe_enq__ENA = rule_ready && rule_enable;
    assign enq           = heard__ENA && heard__RDY;
    assign deq           = pipe_enq__ENA && (beat == S_VAL);

    assign unused_fifo_count = ^fifo_count;

    echo_msg_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (2*WORD_W)
    ) u_fifo (
        .clk       (CLK),
        .rst       (nRST),
        .enq       (enq),
        .enq_data  ({heard_meth, heard_v}),
        .deq       (deq),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        beat_next  = S_HDR;
        pipe_enq_v = make_header(TAG_HEARD);
        case (beat)
            S_HDR: begin
                beat_next  = S_METH;
                pipe_enq_v = make_header(TAG_HEARD);
            end
            S_METH: begin
                beat_next  = S_VAL;
                pipe_enq_v = head[2*WORD_W-1:WORD_W];
            end
            S_VAL: begin
                beat_next  = S_HDR;
                pipe_enq_v = head[WORD_W-1:0];
            end
            default: begin
                beat_next  = S_HDR;
                pipe_enq_v = make_header(TAG_HEARD);
            end
        endcase
    end

    // A reset mid-message discards the partial message; the next one starts at HDR.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            beat <= S_HDR;
        end else if (pipe_enq__ENA) begin
            beat <= beat_next;
        end
    end

`ifdef ECHO_INDICATION_OUTPUT_STATS_EN
    always_ff @(posedge CLK) begin
        if (nRST) begin
            msg_count  <= '0;
            drop_count <= '0;
        end else begin
            if (deq) begin
                msg_count <= msg_count + 16'd1;
            end
            if (heard__ENA && !heard__RDY && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`else
    // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_echo_indication_output.sv
// Scoreboard bench for echo_indication_output: accepted calls push three
// expected words, each outbound beat pops one and compares.
module tb_echo_indication_output;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        heard__ENA;
    logic [31:0] heard_meth;
    logic [31:0] heard_v;
    logic        heard__RDY;
    logic        pipe_enq__ENA;
    logic [31:0] pipe_enq_v;
    logic        pipe_enq__RDY;
    logic        rule_enable;
    logic        rule_ready;
`ifdef ECHO_INDICATION_OUTPUT_STATS_EN
    logic [15:0] msg_count;
    logic [15:0] drop_count;
`endif

    localparam logic [31:0] HDR_WORD = 32'h0003_0001;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    int          exp_msgs  = 0;
    int          exp_drops = 0;
    int          beat_idx  = 0;

    echo_indication_output #(.DEPTH(2), .TAG_HEARD(16'd1)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .heard__ENA    (heard__ENA),
        .heard_meth    (heard_meth),
        .heard_v       (heard_v),
        .heard__RDY    (heard__RDY),
        .pipe_enq__ENA (pipe_enq__ENA),
        .pipe_enq_v    (pipe_enq_v),
        .pipe_enq__RDY (pipe_enq__RDY),
        .rule_enable   (rule_enable),
        .rule_ready    (rule_ready)
`ifdef ECHO_INDICATION_OUTPUT_STATS_EN
        ,
        .msg_count     (msg_count),
        .drop_count    (drop_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Scoreboard: pop/compare outbound words, push words for accepted calls.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            exp_q.delete();
            beat_idx  = 0;
            exp_msgs  = 0;
            exp_drops = 0;
        end else begin
            if (pipe_enq__ENA === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_word: got %h, required no beat", pipe_enq_v);
                end else begin
                    logic [31:0] w;
                    w = exp_q.pop_front();
                    if (pipe_enq_v !== w) begin
                        n_fail++;
                        $display("FAIL sb_word: got %h, required %h", pipe_enq_v, w);
                    end
                end
                beat_idx = (beat_idx == 2) ? 0 : beat_idx + 1;
                if (beat_idx == 0) exp_msgs++;
            end
            if (heard__ENA === 1'b1 && heard__RDY === 1'b1) begin
                exp_q.push_back(HDR_WORD);
                exp_q.push_back(heard_meth);
                exp_q.push_back(heard_v);
            end
            if (heard__ENA === 1'b1 && heard__RDY === 1'b0 && exp_drops < 65535) begin
                exp_drops++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge CLK);
            #2;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_call(input logic [31:0] m, input logic [31:0] v);
        @(posedge CLK);
        #1;
        heard__ENA = 1'b1;
        heard_meth = m;
        heard_v    = v;
        @(posedge CLK);
        #1;
        heard__ENA = 1'b0;
    endtask

    task automatic test_reset;
        nRST          = 1'b1;
        heard__ENA    = 1'b0;
        heard_meth    = '0;
        heard_v       = '0;
        pipe_enq__RDY = 1'b1;
        rule_enable   = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (heard__RDY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_heard_rdy: got %b, required 0", heard__RDY);
        end
        n_checks++;
        if (pipe_enq__ENA !== 1'b0 || rule_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ena=%b ready=%b, required 0 0", pipe_enq__ENA, rule_ready);
        end
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (heard__RDY !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_heard_rdy: got %b, required 1", heard__RDY);
        end
        n_checks++;
        if (rule_ready !== 1'b0 || pipe_enq_v !== HDR_WORD) begin
            n_fail++;
            $display("FAIL post_reset_idle: got ready=%b v=%h, required 0 %h", rule_ready, pipe_enq_v, HDR_WORD);
        end
    endtask

    task automatic test_single;
        logic [31:0] exp_words [3];
        exp_words[0] = HDR_WORD;
        exp_words[1] = 32'h0000_0005;
        exp_words[2] = 32'hDEAD_BEEF;
        send_call(32'h0000_0005, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            n_checks++;
            if (pipe_enq__ENA !== 1'b1 || pipe_enq_v !== exp_words[k]) begin
                n_fail++;
                $display("FAIL single_beat%0d: got ena=%b v=%h, required 1 %h", k, pipe_enq__ENA, pipe_enq_v, exp_words[k]);
            end
        end
        @(negedge CLK);
        n_checks++;
        if (pipe_enq__ENA !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got ena=%b, required 0", pipe_enq__ENA);
        end
    endtask

    task automatic test_full;
        int fires;
        bit ok;
        pipe_enq__RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            heard__ENA = 1'b1;
            heard_meth = 32'h100 + 32'(i);
            heard_v    = 32'hA000_0000 + 32'(i);
            @(negedge CLK);
            n_checks++;
            if (heard__RDY !== (i < 2)) begin
                n_fail++;
                $display("FAIL full_rdy_call%0d: got %b, required %b", i, heard__RDY, (i < 2));
            end
        end
        @(posedge CLK);
        #1;
        heard__ENA = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (rule_ready !== 1'b0 || pipe_enq__ENA !== 1'b0) begin
            n_fail++;
            $display("FAIL full_blocked: got ready=%b ena=%b, required 0 0", rule_ready, pipe_enq__ENA);
        end
        @(posedge CLK);
        #1;
        pipe_enq__RDY = 1'b1;
        fires = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (pipe_enq__ENA === 1'b1) fires++;
            if (c < 3) begin
                n_checks++;
                if (heard__RDY !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_rdy_before_pop c%0d: got %b, required 0", c, heard__RDY);
                end
            end else if (c == 3) begin
                n_checks++;
                if (heard__RDY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_rdy_after_pop: got %b, required 1", heard__RDY);
                end
            end
        end
        n_checks++;
        if (fires != 6) begin
            n_fail++;
            $display("FAIL full_word_count: got %0d, required 6", fires);
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL full_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_stall;
        bit ok;
        send_call(32'h1234_5678, 32'h0BAD_F00D);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        pipe_enq__RDY = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            n_checks++;
            if (pipe_enq__ENA !== 1'b0 || pipe_enq_v !== 32'h1234_5678) begin
                n_fail++;
                $display("FAIL stall_hold c%0d: got ena=%b v=%h, required 0 12345678", c, pipe_enq__ENA, pipe_enq_v);
            end
        end
        @(posedge CLK);
        #1;
        pipe_enq__RDY = 1'b1;
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_gating;
        bit ok;
        rule_enable = 1'b0;
        send_call(32'h0000_00AA, 32'h0000_00BB);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            n_checks++;
            if (rule_ready !== 1'b1 || pipe_enq__ENA !== 1'b0 || pipe_enq_v !== HDR_WORD) begin
                n_fail++;
                $display("FAIL gating c%0d: got ready=%b ena=%b v=%h, required 1 0 %h", c, rule_ready, pipe_enq__ENA, pipe_enq_v, HDR_WORD);
            end
        end
        @(posedge CLK);
        #1;
        rule_enable = 1'b1;
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL gating_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        send_call(32'h0000_0777, 32'h0000_0888);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (pipe_enq__ENA !== 1'b0 || heard__RDY !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_during: got ena=%b rdy=%b, required 0 0", pipe_enq__ENA, heard__RDY);
        end
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (rule_ready !== 1'b0 || pipe_enq_v !== HDR_WORD || heard__RDY !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_after: got ready=%b v=%h rdy=%b, required 0 %h 1", rule_ready, pipe_enq_v, heard__RDY, HDR_WORD);
        end
        send_call(32'h0000_0999, 32'h0000_0AAA);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            heard__ENA = 1'b1;
            heard_meth = $urandom;
            heard_v    = $urandom;
        end
        @(posedge CLK);
        #1;
        heard__ENA = 1'b0;
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

`ifdef ECHO_INDICATION_OUTPUT_STATS_EN
    task automatic test_stats;
        bit ok;
        pipe_enq__RDY = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge CLK);
            #1;
            heard__ENA = 1'b1;
            heard_meth = 32'(i);
            heard_v    = 32'(i) ^ 32'h5555_5555;
        end
        @(posedge CLK);
        #1;
        heard__ENA    = 1'b0;
        pipe_enq__RDY = 1'b1;
        wait_drain(ok);
        @(posedge CLK);
        #2;
        n_checks++;
        if (!ok || msg_count !== 16'(exp_msgs)) begin
            n_fail++;
            $display("FAIL stats_msg_count: got %0d, required %0d", msg_count, exp_msgs);
        end
        n_checks++;
        if (drop_count !== 16'(exp_drops)) begin
            n_fail++;
            $display("FAIL stats_drop_count: got %0d, required %0d", drop_count, exp_drops);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full();
        test_stall();
        test_gating();
        test_reset_mid();
        test_back_to_back();
`ifdef ECHO_INDICATION_OUTPUT_STATS_EN
        test_stats();
`endif
        repeat (2) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_indication_output.md
Name: echo_indication_output

Overview:
- Transmit end of the echo indication portal.
- Accepts `heard(meth, v)` method calls, buffers them in a small FIFO, and serializes each call into a 3-word, 32-bit message on an outbound pipe: header, meth, v.
- The peer receive end reassembles the 96-bit message and dispatches it on tag 1.

Parameters:
- DEPTH, 2, number of buffered heard calls (power of 2, ≥2).
- TAG_HEARD, 1, 16-bit method tag placed in the header word.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- nRST  in  1  reset; synchronous, active-high (1 = reset).
- heard__ENA  in  1  method enable.
- heard_meth  in  32  meth argument.
- heard_v  in  32  v argument.
- heard__RDY  out  1  method ready (FIFO not full).
- pipe_enq__ENA  out  1  outbound word valid/fire.
- pipe_enq_v  out  32  outbound word.
- pipe_enq__RDY  in  1  downstream can accept a word.
- rule_enable  in  1  bit 0 = scheduler permission for the drain rule.
- rule_ready  out  1  bit 0 = drain rule can fire.

Behaviour:
- Reset (nRST=1 at a clock edge):
  - FIFO emptied.
  - Beat FSM = HDR.
  - heard__RDY=0 during reset, 1 on the first cycle after.
  - pipe_enq__ENA=0, rule_ready=0.
  - Reset mid-message abandons the partial message; there is no resume.
- Enqueue:
  - Fires when heard__ENA && heard__RDY.
  - Stores {meth, v} at the tail.
  - heard__ENA while not ready is ignored; no state change.
  - heard__RDY = (count != DEPTH). It does not depend on same-cycle dequeue, so there is no full bypass.
- Drain rule:
  - rule_ready[0] = (count != 0) && pipe_enq__RDY.
  - pipe_enq__ENA = rule_ready[0] && rule_enable[0].
- Beat FSM (HDR -> METH -> VAL -> HDR) advances only on pipe_enq__ENA:
  - HDR: pipe_enq_v = {16'd3, TAG_HEARD}, i.e. 32'h0003_0001 by default.
  - METH: pipe_enq_v = head.meth.
  - VAL: pipe_enq_v = head.v. The FIFO pops on this beat.
- pipe_enq_v is driven from the FIFO head combinationally and is stable while the FSM is held.
- Latency: a call accepted at edge N can produce its header with pipe_enq__ENA high in cycle N+1. Three beats minimum per message.
- Throughput: 1 message per 3 cycles with no stalls.
- Simultaneous enqueue and VAL-pop in the same cycle: legal when not full; count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Stalls (pipe_enq__RDY=0 or rule_enable=0) hold the FSM and FIFO; no beat is dropped or duplicated.

Optional Feature:
- Macro: ECHO_INDICATION_OUTPUT_STATS_EN.
- Defined:
  - Adds output msg_count [15:0], reset to 0.
  - Increments on each VAL beat transfer; wraps 16'hFFFF -> 0.
  - Adds output drop_count [15:0], reset to 0. It increments when heard__ENA=1 && heard__RDY=0, saturating at 16'hFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package echo_portal_pkg:
  - TAG_HEARD.
  - Header length constant (3).
  - Beat-state enum {HDR, METH, VAL}.
  - Word width 32.
  - RULE_COUNT = 0 for this block.
- One sub-module: echo_msg_fifo. It is a parameterized DEPTH x 64 synchronous FIFO with enq/deq/full/empty/count.
- The FSM and muxing stay in the top.

Test Plan:
- Single call: reset, then heard(meth=32'h0000_0005, v=32'hDEAD_BEEF) with pipe_enq__RDY=1 and rule_enable=1 -> words 32'h0003_0001, 32'h0000_0005, 32'hDEAD_BEEF on 3 consecutive cycles starting the cycle after acceptance.
- Full: hold pipe_enq__RDY=0, issue 3 calls -> first 2 accepted, heard__RDY=0 after the 2nd, 3rd ignored. Release -> exactly 6 words in order; heard__RDY returns 1 after the first VAL pop.
- Stall mid-message: drop pipe_enq__RDY during the METH beat for 4 cycles -> pipe_enq_v holds meth, pipe_enq__ENA=0; resumes with no duplicate or missing word.
- Scheduler gating: rule_enable=0 with a non-empty FIFO -> rule_ready=1, pipe_enq__ENA=0, FSM frozen.
- Reset mid-message: assert nRST after the HDR beat -> next cycle FIFO empty, FSM=HDR. A new call then starts with the header.
- Stats (macro defined):
  - 70000 back-to-back messages -> msg_count = 70000 mod 65536 = 4464.
  - 5 attempts while full -> drop_count = 5.
